prime_number_detector: RTL and testbench

PRIME_NUMBER_DETECTOR -- requirements
Module: prime_number_detector

---
 rtl/prime_number_detector.sv | 85 ++++++++
 tb/tb_prime_number_detector.sv | 125 ++++++++++++
 2 files changed

// File: rtl/prime_number_detector.sv
// Registered smallest-prime-factor, primality and divisibility flags for two 8-bit operands.
// Optional macro PRIME_PIPE_EN adds an input register stage (latency 2 instead of 1).
module prime_number_detector (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] C,
    output logic [3:0] D
);

    // Trial division by the primes up to 13 is enough for any 8-bit value.
    function automatic logic [7:0] f_spf(input logic [7:0] v);
        logic [7:0] res;
        if (v < 8'd2) begin
            res = 8'd0;
        end else if ((v % 8'd2) == 8'd0) begin
            res = 8'd2;
        end else if ((v % 8'd3) == 8'd0) begin
            res = 8'd3;
        end else if ((v % 8'd5) == 8'd0) begin
            res = 8'd5;
        end else if ((v % 8'd7) == 8'd0) begin
            res = 8'd7;
        end else if ((v % 8'd11) == 8'd0) begin
            res = 8'd11;
        end else if ((v % 8'd13) == 8'd0) begin
            res = 8'd13;
        end else begin
            res = v;
        end
        return res;
    endfunction

    function automatic logic f_is_prime(input logic [7:0] v);
        return (v >= 8'd2) && (f_spf(v) == v);
    endfunction

    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_valid_in;
    logic [7:0] w_rem;
    logic       w_div;

`ifdef PRIME_PIPE_EN
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_valid1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_valid1 <= 1'b0;
        end else begin
            r_a      <= A;
            r_b      <= B;
            r_valid1 <= 1'b1;
        end
    end

    assign w_a        = r_a;
    assign w_b        = r_b;
    assign w_valid_in = r_valid1;
`else
    assign w_a        = A;
    assign w_b        = B;
    assign w_valid_in = 1'b1;
`endif

    // Remainder is only formed for a non-zero divisor; B=0 never counts as dividing.
    assign w_rem = (w_b != 8'd0) ? (w_a % w_b) : 8'd1;
    assign w_div = (w_b != 8'd0) && (w_rem == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            C <= 8'd0;
            D <= 4'b0000;
        end else begin
            C <= f_spf(w_a);
            D <= {w_valid_in, w_div, f_is_prime(w_b), f_is_prime(w_a)};
        end
    end

endmodule

// File: tb/tb_prime_number_detector.sv
// Directed self-checking bench for prime_number_detector; adapts latency to PRIME_PIPE_EN.
module tb_prime_number_detector;

`ifdef PRIME_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A   = 8'd0;
    logic [7:0] B   = 8'd0;
    logic [7:0] C;
    logic [3:0] D;

    int n_total = 0;
    int n_bad   = 0;

    prime_number_detector dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp_c, input logic [3:0] exp_d);
        n_total++;
        assert (C === exp_c) else begin
            n_bad++;
            $error("FAIL %s C got %0d want %0d", tag, C, exp_c);
        end
        n_total++;
        assert (D === exp_d) else begin
            n_bad++;
            $error("FAIL %s D got %0d want %0d", tag, D, exp_d);
        end
    endtask

    // Drive operands just after an edge, then sample #1 after the edge where the result lands.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input string tag,
                         input logic [7:0] exp_c, input logic [3:0] exp_d);
        A = a;
        B = b;
        repeat (LAT) @(posedge clk);
        #1;
        check(tag, exp_c, exp_d);
    endtask

    initial begin
        A   = 8'd77;
        B   = 8'd7;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'd0, 4'd0);

        rst = 1'b0;
        apply(8'd0, 8'd8, "release_a0_b8", 8'd0, 4'd12);

        apply(8'd6,   8'd8, "a6",   8'd2, 4'd8);
        apply(8'd1,   8'd8, "a1",   8'd0, 4'd8);
        apply(8'd254, 8'd8, "a254", 8'd2, 4'd8);
        apply(8'd100, 8'd8, "a100", 8'd2, 4'd8);
        apply(8'd56,  8'd8, "a56",  8'd2, 4'd12);

        apply(8'd5, 8'd8, "a5", 8'd5, 4'd9);
        apply(8'd79, 8'd8, "a79_hold0", 8'd79, 4'd9);
        @(posedge clk);
        #1;
        check("a79_hold1", 8'd79, 4'd9);
        @(posedge clk);
        #1;
        check("a79_hold2", 8'd79, 4'd9);
        apply(8'd23,  8'd8, "a23",  8'd23,  4'd9);
        apply(8'd251, 8'd8, "a251", 8'd251, 4'd9);
        apply(8'd13,  8'd8, "a13",  8'd13,  4'd9);
        apply(8'd97,  8'd8, "a97",  8'd97,  4'd9);

        apply(8'd121, 8'd11, "a121_b11", 8'd11, 4'd14);
        apply(8'd169, 8'd0,  "a169_b0",  8'd13, 4'd8);
        apply(8'd2,   8'd2,  "a2_b2",    8'd2,  4'd15);
        apply(8'd0,   8'd0,  "a0_b0",    8'd0,  4'd8);
        apply(8'd255, 8'd255, "a255_b255", 8'd3, 4'd12);
        apply(8'd221, 8'd13, "a221_b13", 8'd13, 4'd14);
        apply(8'd3,   8'd6,  "a3_b6",    8'd3,  4'd9);

        // Back-to-back operands, one per cycle, checked at the pipeline depth.
        A = 8'd9;
        B = 8'd3;
        @(posedge clk);
        #1;
        A = 8'd11;
        B = 8'd4;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("stream_a9_b3", 8'd3, 4'd14);
        @(posedge clk);
        #1;
        check("stream_a11_b4", 8'd11, 4'd9);

        // Mid-stream reset with A=97 held.
        A = 8'd97;
        B = 8'd8;
        repeat (3) @(posedge clk);
        #1;
        check("stream_a97", 8'd97, 4'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset", 8'd0, 4'd0);
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        check("after_midreset", 8'd97, 4'd9);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
